// File: rtl/if_pkg.sv
// Shared defaults and the fetch-entry type for the instruction prefetch stage.
package if_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned PC_STEP_DEF = 4;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  // One buffered instruction; pc is the fetch address plus PC_STEP.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instruction;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; flush wins over push and pop.
module if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DepthCnt);
    count   = count_q;
    rdata   = mem_q[rptr_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: issues in-order fetches into a small buffer, flushes on branch.
// Defining IF_PERF_CNT_EN adds stall_cycles, empty_cycles and flush_count outputs.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter int unsigned       PC_STEP  = PC_STEP_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        empty_cycles,
  output logic [31:0]        flush_count
`endif
);

  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = INSTR_W + ADDR_W;
  localparam logic [CntW:0] DepthSum = (CntW + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] Step = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   discard_q, discard_d;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     inflight;
  logic [EntryW-1:0] fifo_rdata;
  logic              fifo_empty, fifo_full;
  logic              grant, resp_ok, push, pop;

  if_fifo #(
    .WIDTH(EntryW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(branch_taken),
    .push (push),
    .wdata({imem_rdata, resp_pc_q + Step}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_comb begin
    inflight    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    imem_req    = !rst && !branch_taken && (inflight < DepthSum);
    imem_addr   = fetch_pc_q;
    grant       = imem_req && imem_gnt;
    resp_ok     = imem_rvalid && (outstanding_q != '0);
    push        = resp_ok && !branch_taken && (discard_q == '0);
    instr_valid = !fifo_empty;
    pop         = instr_valid && !freeze && !branch_taken;
    instruction = instr_valid ? fifo_rdata[EntryW-1 -: INSTR_W] : '0;
    pc          = instr_valid ? fifo_rdata[ADDR_W-1:0] : '0;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    case ({grant, resp_ok})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // resp_pc tracks the address of the oldest response that will be kept.
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      resp_pc_d  = branch_addr;
      discard_d  = outstanding_q - CntW'(resp_ok);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + Step;
      if (push)  resp_pc_d  = resp_pc_q + Step;
      if (resp_ok && (discard_q != '0)) discard_d = discard_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      empty_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (instr_valid && freeze) stall_cycles <= stall_cycles + 32'd1;
      if (!instr_valid)          empty_cycles <= empty_cycles + 32'd1;
      if (branch_taken)          flush_count  <= flush_count + 32'd1;
    end
  end
`endif

  // A response with nothing in flight is ignored above; flag it for the integrator.
  a_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding_q == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full));

endmodule
